// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FP80 load/store integer converters of the 8087
// datapath: FP80 field widths and bias, the converter state encoding, the
// rounding-mode encodings used by the store converters, and a packing helper.
// No ports (package).
// -----------------------------------------------------------------------------
package fpu_pkg;

    // FP80 format constants
    localparam int          FP80_EXP_BIAS = 16383;
    localparam logic [14:0] FP80_EXP_MAX  = 15'h7FFF;
    localparam int          EXP_W         = 15;
    localparam int          MANT_W        = 64;
    localparam int          FP80_W        = 1 + EXP_W + MANT_W;

    // Converter state encoding (IDLE must be the reset encoding)
    typedef enum logic [0:0] {
        CVT_IDLE = 1'b0,
        CVT_NORM = 1'b1
    } cvt_state_e;

    // x87 rounding-control encodings, shared with the store converters
    localparam logic [1:0] RND_NEAREST = 2'b00;
    localparam logic [1:0] RND_DOWN    = 2'b01;
    localparam logic [1:0] RND_UP      = 2'b10;
    localparam logic [1:0] RND_ZERO    = 2'b11;

    // Assemble an FP80 word from its fields {sign, exp, mant}
    function automatic logic [FP80_W-1:0] fp80_pack(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [MANT_W-1:0] mant
    );
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fpu_lzc16.sv
// -----------------------------------------------------------------------------
// fpu_lzc16
// 16-bit leading-zero counter. Returns the number of zero bits above the most
// significant set bit; returns 16 when the input is all zeros. Purely
// combinational so it can sit in the normalization path of the int loaders.
// Ports:
//   i_data  [15:0] in   value to scan
//   o_count [4:0]  out  leading-zero count (0..16)
// -----------------------------------------------------------------------------
module fpu_lzc16 (
    input  logic [15:0] i_data,
    output logic [4:0]  o_count
);

    // Scan upward; the highest set bit is the last one to write the count
    always_comb begin
        o_count = 5'd16;
        for (int i = 0; i < 16; i++) begin
            o_count = i_data[i] ? 5'(15 - i) : o_count;
        end
    end

endmodule

// File: rtl/fpu_int16_to_fp80.sv
// -----------------------------------------------------------------------------
// fpu_int16_to_fp80
// Converts a 16-bit two's-complement integer to FP80 extended precision
// (FILD word). The conversion is always exact, so no exception flags exist.
// Default build normalizes one bit per cycle; with FPU_FAST_NORM_EN defined a
// leading-zero counter normalizes in a single NORM cycle. Results are
// bit-identical between builds, only latency differs.
// Ports:
//   clk     in   1   clock
//   reset   in   1   asynchronous, active-high reset
//   enable  in   1   start request, sampled only in IDLE
//   int_in  in   16  signed integer operand
//   fp_out  out  80  {sign, exp[14:0], mant[63:0]}, explicit integer bit mant[63]
//   done    out  1   one-cycle completion pulse
//   busy    out  1   conversion in progress
// Configuration macro: FPU_FAST_NORM_EN
// -----------------------------------------------------------------------------
module fpu_int16_to_fp80
    import fpu_pkg::*;
#(
    parameter int EXP_BIAS = FP80_EXP_BIAS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] int_in,
    output logic [79:0] fp_out,
    output logic        done,
    output logic        busy
);

    // Exponent of a value whose MSB sits at bit 15 of the magnitude
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + 15);

    cvt_state_e        r_state;
    logic              r_sign;
    logic [15:0]       r_mag;
    logic [EXP_W-1:0]  r_exp;
    logic [79:0]       r_fp_out;
    logic              r_done;
    logic              r_busy;

    logic              w_in_neg;
    logic [15:0]       w_in_mag;
    logic              w_in_zero;
    logic              w_norm_last;
    logic [15:0]       w_mag_norm;
    logic [EXP_W-1:0]  w_exp_norm;

    // -32768 negates to itself, which is exactly 0x8000 as an unsigned magnitude
    assign w_in_neg  = int_in[15];
    assign w_in_mag  = w_in_neg ? (16'd0 - int_in) : int_in;
    assign w_in_zero = (int_in == 16'd0);

`ifdef FPU_FAST_NORM_EN
    logic [4:0] w_lz;

    fpu_lzc16 u_lzc (
        .i_data  (r_mag),
        .o_count (w_lz)
    );

    // r_mag is never zero in NORM, so lz is at most 15 and exp stays >= bias
    assign w_norm_last = 1'b1;
    assign w_mag_norm  = r_mag << w_lz;
    assign w_exp_norm  = r_exp - {{(EXP_W-5){1'b0}}, w_lz};
`else
    // Iterative build: finish once the shifting has brought the MSB to bit 15
    assign w_norm_last = r_mag[15];
    assign w_mag_norm  = r_mag;
    assign w_exp_norm  = r_exp;
`endif

    // Conversion FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= CVT_IDLE;
            r_sign   <= 1'b0;
            r_mag    <= 16'h0000;
            r_exp    <= {EXP_W{1'b0}};
            r_fp_out <= 80'h0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CVT_IDLE: begin
                    if (enable) begin
                        r_sign <= w_in_neg;
                        r_mag  <= w_in_mag;
                        r_exp  <= EXP_TOP;
                        if (w_in_zero) begin
                            // Zero is always +0; the sign bit cannot be set here
                            r_fp_out <= 80'h0;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= CVT_NORM;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= CVT_IDLE;
                    end
                end
                CVT_NORM: begin
                    if (w_norm_last) begin
                        r_fp_out <= fp80_pack(r_sign, w_exp_norm, {w_mag_norm, 48'h0});
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= CVT_IDLE;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 15'd1;
                    end
                end
                default: begin
                    r_state <= CVT_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fp_out = r_fp_out;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule

// File: tb/tb_fpu_int16_to_fp80.sv
// -----------------------------------------------------------------------------
// tb_fpu_int16_to_fp80
// Scoreboard bench for fpu_int16_to_fp80. Each accepted request pushes its
// expected FP80 result and completion cycle; the monitor pops on done.
// Honors FPU_FAST_NORM_EN for expected latencies.
// -----------------------------------------------------------------------------
module tb_fpu_int16_to_fp80;

`ifdef FPU_FAST_NORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] int_in;
    logic [79:0] fp_out;
    logic        done;
    logic        busy;

    typedef struct {
        logic [79:0] fp;
        int          due;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    fpu_int16_to_fp80 dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .int_in (int_in),
        .fp_out (fp_out),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Independent reference: value-based normalization of the signed integer
    function automatic logic [79:0] ref_fp(input logic [15:0] x);
        int          v;
        int          m;
        int          k;
        logic [63:0] mant;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        if (m == 0) return 80'h0;
        k = 0;
        for (int b = 0; b < 16; b++) if (((m >> b) & 1) == 1) k = b;
        mant = 64'(m) << (63 - k);
        return {(v < 0), 15'(16383 + k), mant};
    endfunction

    function automatic int ref_lat(input logic [15:0] x);
        int v;
        int m;
        int k;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        if (m == 0) return 0;
        if (FAST) return 1;
        k = 0;
        for (int b = 0; b < 16; b++) if (((m >> b) & 1) == 1) k = b;
        return 16 - k;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 80'd1, 80'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("fp_out", fp_out, mon_e.fp);
                check_val("latency", 80'(cyc), 80'(mon_e.due));
            end
        end
    end

    // Called at a negedge; waits for IDLE, issues one request, returns at next negedge
    task automatic run_exp(input logic [15:0] x, input logic [79:0] e_fp, input int e_lat);
        int guard;
        guard = 0;
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_val("idle_wait", 80'(busy), 80'd0);
        enable = 1'b1;
        int_in = x;
        sb_q.push_back('{e_fp, cyc + 1 + e_lat});
        @(negedge clk);
        enable = 1'b0;
        int_in = 16'($urandom);
        check_val("busy_start", 80'(busy), 80'(x != 16'd0));
    endtask

    task automatic run_model(input logic [15:0] x);
        run_exp(x, ref_fp(x), ref_lat(x));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_val("idle_timeout", 80'(busy), 80'd0);
    endtask

    initial begin
        int guard;
        int dcnt;
        reset  = 1'b1;
        enable = 1'b0;
        int_in = 16'h0000;
        repeat (2) @(negedge clk);
        check_val("rst_fp_out", fp_out, 80'h0);
        check_val("rst_done", 80'(done), 80'd0);
        check_val("rst_busy", 80'(busy), 80'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed values with hand-derived results
        run_exp(16'h0001, 80'h3FFF_8000000000000000, FAST ? 1 : 16);
        run_exp(16'h8000, 80'hC00E_8000000000000000, 1);
        run_exp(16'd100,  80'h4005_C800000000000000, FAST ? 1 : 10);
        run_exp(16'hFFFF, 80'hBFFF_8000000000000000, FAST ? 1 : 16);
        run_exp(16'h0000, 80'h0, 0);
        run_exp(16'h7FFF, 80'h400D_FFFE000000000000, FAST ? 1 : 2);
        run_exp(16'h0000, 80'h0, 0);

        // enable held high; operand changes during NORM must not leak in
        wait_idle();
        enable = 1'b1;
        int_in = 16'd5;
        sb_q.push_back('{ref_fp(16'd5), cyc + 1 + ref_lat(16'd5)});
        @(negedge clk);
        int_in = 16'd7;
        guard = 0;
        while (!done && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_val("hold_done_seen", 80'(done), 80'd1);
        // enable coincident with done is accepted at the next edge
        sb_q.push_back('{ref_fp(16'd7), cyc + 1 + ref_lat(16'd7)});
        @(negedge clk);
        enable = 1'b0;
        check_val("hold_busy_second", 80'(busy), 80'd1);

        // Abort a conversion of 3 with reset
        wait_idle();
        enable = 1'b1;
        int_in = 16'h0003;
        @(negedge clk);
        enable = 1'b0;
        if (!FAST) repeat (4) @(negedge clk);
        check_val("abort_busy_before", 80'(busy), 80'd1);
        reset = 1'b1;
        #1;
        check_val("abort_fp_out", fp_out, 80'h0);
        check_val("abort_done", 80'(done), 80'd0);
        check_val("abort_busy", 80'(busy), 80'd0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_val("abort_no_done", 80'(dcnt), 80'd0);

        // Strided sweep plus random operands against the reference model
        for (int i = 0; i < 65536; i += 97) run_model(16'(i));
        run_model(16'h8001);
        run_model(16'h4000);
        run_model(16'hC000);
        for (int i = 0; i < 300; i++) run_model(16'($urandom));

        wait_idle();
        repeat (3) @(negedge clk);
        check_val("sb_empty", 80'(sb_q.size()), 80'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
